// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing, frame size and receiver state encoding.
// Used by uart_rx and uart_tx.
package uart_pkg;

    localparam int CLKS_PER_BIT = 104;
    localparam int DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received byte and status strobes out.
// master = the receiver, slave = the line driver / byte consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rxd;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (input rxd, output rx_byte, rx_valid, frame_err, rx_busy);
    modport slave  (output rxd, input rx_byte, rx_valid, frame_err, rx_busy);

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs.
// Resets to 1 so an idle-high line does not look like an edge coming out of reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with framing-error reporting and false-start rejection.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rxd_s;
    logic                 bit_val;
    rx_state_t            state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_n;
    logic                 rx_valid_q, rx_valid_n;
    logic                 frame_err_q, frame_err_n;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rxd),
        .q   (rxd_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Vote over the previous two samples and the current one, so every decision lands one clock past the bit centre.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF_BIT);
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rxd_s};
        end
    end

    assign bit_val = majority3(hist[1], hist[0], rxd_s);
`else
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF_BIT - 1);
    assign bit_val = rxd_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            rx_byte_q   <= rx_byte_n;
            rx_valid_q  <= rx_valid_n;
            frame_err_q <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        shreg_n     = shreg;
        rx_byte_n   = rx_byte_q;
        rx_valid_n  = 1'b0;
        frame_err_n = 1'b0;

        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end

            START: begin
                if (cnt == START_LAST) begin
                    if (bit_val) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            // LSB arrives first; shifting in at the MSB leaves it in bit 0 after the last shift.
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {bit_val, shreg[DATA_BITS-1:1]};
                    idx_n   = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (bit_val) begin
                        rx_byte_n  = shreg;
                        rx_valid_n = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = BREAK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            BREAK: begin
                if (rxd_s) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.rx_byte   = rx_byte_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rx_busy   = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed serial frames with hand-computed bytes,
// monitor pops expectations on every rx_valid / frame_err strobe.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 104;
`ifdef UART_RX_MAJORITY_EN
    localparam int         LAT        = 992;
    localparam logic [7:0] GLITCH_EXP = 8'h42;
`else
    localparam int         LAT        = 991;
    localparam logic [7:0] GLITCH_EXP = 8'h4A;
`endif

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   pulse_count = 0;
    int   last_pulse_cyc = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.rx_valid || bus.frame_err) begin
            pulse_count++;
            last_pulse_cyc = cyc;
            vectors++;
            if (bus.rx_valid && bus.frame_err) begin
                miscompares++;
                $display("[TB] FAIL both_pulses: rx_valid=1 frame_err=1, required exactly one");
            end else if (sb_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_pulse: valid=%0b err=%0b byte=%02h, required no pulse",
                         bus.rx_valid, bus.frame_err, bus.rx_byte);
            end else begin
                mon_e = sb_q.pop_front();
                if (bus.frame_err != mon_e.is_err || bus.rx_byte != mon_e.data) begin
                    miscompares++;
                    $display("[TB] FAIL sb_pulse: err=%0b byte=%02h, required err=%0b byte=%02h",
                             bus.frame_err, bus.rx_byte, mon_e.is_err, mon_e.data);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        vectors++;
        if (actual < lo || actual > hi) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic expectByte(input logic [7:0] data, input bit is_err);
        exp_t e;
        e.is_err = is_err;
        e.data   = data;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 10-bit frame; call #1 after a rising edge. glitch_bit/abort_bit < 0 disable those options.
    task automatic applyStimulus(input logic [7:0] data, input bit stop_ok, input int glitch_bit,
                                 input int abort_bit, output int start_cyc);
        logic [9:0] frame;
        frame     = {stop_ok, data, 1'b0};
        start_cyc = cyc;
        for (int n = 0; n < 10; n++) begin
            for (int j = 0; j < CPB; j++) begin
                if (abort_bit >= 0 && n == abort_bit + 1 && j == CPB / 2) begin
                    bus.rxd = 1'b1;
                    return;
                end
                if (glitch_bit >= 0 && n == glitch_bit + 1 && j == CPB / 2)
                    bus.rxd = ~frame[n];
                else
                    bus.rxd = frame[n];
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int t0, pa, pb, p0, busy_cnt;
        rst     = 1'b1;
        bus.rxd = 1'b1;
        idle(5);
        checkOutput("reset_rx_byte", 32'(bus.rx_byte), 32'h00);
        checkOutput("reset_rx_valid", 32'(bus.rx_valid), 0);
        checkOutput("reset_frame_err", 32'(bus.frame_err), 0);
        checkOutput("reset_rx_busy", 32'(bus.rx_busy), 0);
        rst = 1'b0;
        idle(10);

        // Single good frame, latency from start bit
        p0 = pulse_count;
        expectByte(8'h42, 1'b0);
        applyStimulus(8'h42, 1'b1, -1, -1, t0);
        checkOutput("single_pulse_count", 32'(pulse_count - p0), 1);
        checkRange("single_latency", last_pulse_cyc - t0, LAT - 1, LAT + 1);
        idle(20);

        // Back-to-back frames, no idle gap
        p0 = pulse_count;
        expectByte(8'hA5, 1'b0);
        expectByte(8'h5A, 1'b0);
        applyStimulus(8'hA5, 1'b1, -1, -1, t0);
        pa = last_pulse_cyc;
        applyStimulus(8'h5A, 1'b1, -1, -1, t0);
        pb = last_pulse_cyc;
        checkOutput("b2b_pulse_count", 32'(pulse_count - p0), 2);
        checkRange("b2b_spacing", pb - pa, 1038, 1042);
        idle(20);

        // False start: 20-clock low pulse
        p0 = pulse_count;
        bus.rxd = 1'b0;
        idle(20);
        checkOutput("false_start_busy_high", 32'(bus.rx_busy), 1);
        bus.rxd = 1'b1;
        busy_cnt = 0;
        while (bus.rx_busy && busy_cnt < 60) begin
            idle(1);
            busy_cnt++;
        end
        checkRange("false_start_busy_drop", busy_cnt, 0, 53);
        idle(200);
        checkOutput("false_start_no_pulse", 32'(pulse_count - p0), 0);

        // Good frame, then a frame whose stop bit is low, then a held-low line
        p0 = pulse_count;
        expectByte(8'h42, 1'b0);
        applyStimulus(8'h42, 1'b1, -1, -1, t0);
        idle(10);
        expectByte(8'h42, 1'b1);
        applyStimulus(8'h3C, 1'b0, -1, -1, t0);
        idle(2000);
        checkOutput("break_pulse_count", 32'(pulse_count - p0), 2);
        checkOutput("break_busy_held", 32'(bus.rx_busy), 1);
        checkOutput("break_rx_byte", 32'(bus.rx_byte), 32'h42);
        bus.rxd = 1'b1;
        idle(10);
        checkOutput("break_release_idle", 32'(bus.rx_busy), 0);
        p0 = pulse_count;
        expectByte(8'h55, 1'b0);
        applyStimulus(8'h55, 1'b1, -1, -1, t0);
        checkOutput("after_break_pulse_count", 32'(pulse_count - p0), 1);
        idle(20);

        // Reset in the middle of bit 4 of 0xFF
        p0 = pulse_count;
        applyStimulus(8'hFF, 1'b1, -1, 4, t0);
        rst = 1'b1;
        idle(3);
        checkOutput("midreset_busy", 32'(bus.rx_busy), 0);
        checkOutput("midreset_rx_byte", 32'(bus.rx_byte), 32'h00);
        rst = 1'b0;
        idle(1200);
        checkOutput("midreset_no_pulse", 32'(pulse_count - p0), 0);
        expectByte(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b1, -1, -1, t0);
        checkOutput("after_reset_pulse_count", 32'(pulse_count - p0), 1);
        idle(20);

        // One-clock inverted glitch at the centre of data bit 3
        p0 = pulse_count;
        expectByte(GLITCH_EXP, 1'b0);
        applyStimulus(8'h42, 1'b1, 3, -1, t0);
        checkOutput("glitch_pulse_count", 32'(pulse_count - p0), 1);
        idle(20);

        busy_cnt = 0;
        while (sb_q.size() != 0 && busy_cnt < 2000) begin
            idle(1);
            busy_cnt++;
        end
        checkOutput("scoreboard_drain", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; downstream counterpart of uart_tx.
- Consumes the serial line (uart_tx txd in loopback, or the board RX pin) and delivers one byte per frame with a single-cycle valid strobe.
- Targets the 12 MHz system clock at 115200 baud (104 clocks/bit), with framing-error reporting and false-start rejection.

Parameters:
- CLKS_PER_BIT, 104, system clocks per bit; legal range >= 8. Counter width is $clog2(CLKS_PER_BIT).
- HALF_BIT, CLKS_PER_BIT/2, clocks from start-edge detect to mid-start sample.

Ports:
- clk  in  1  system clock, 12 MHz
- rst  in  1  synchronous, active-high reset
- rxd  in  1  asynchronous serial input; idles high
- rx_byte  out  8  last correctly framed byte; LSB received first
- rx_valid  out  1  one-cycle pulse; rx_byte is new
- frame_err  out  1  one-cycle pulse; stop bit sampled low
- rx_busy  out  1  high in every state except IDLE

Behaviour:
- Reset state: rx_byte=0x00, rx_valid=0, frame_err=0, rx_busy=0, state=IDLE, counters=0, synchroniser flops=1.
- rxd passes through a 2-flop synchroniser. All decisions use the synchronised value rxd_s.
- IDLE → START when rxd_s==0; baud counter cleared.
- START: counter counts to HALF_BIT-1 (sample point T+52 for the default).
  - If rxd_s==1 at the sample point → IDLE (false start); no outputs change.
  - Otherwise → DATA; counter and bit index cleared.
- DATA: every CLKS_PER_BIT clocks, shift rxd_s into the shift register MSB-first-in, so the first bit lands in bit 0 after 8 shifts.
  - After the 8th sample → STOP.
  - Bit i is sampled at T+HALF_BIT+CLKS_PER_BIT*(i+1).
- STOP: sample after CLKS_PER_BIT clocks (T+988 for the default).
  - rxd_s==1: rx_byte <= shift register and rx_valid=1 on the same edge → IDLE. The transition happens at mid-stop so back-to-back frames are accepted.
  - rxd_s==0: frame_err=1, rx_byte unchanged → BREAK.
- BREAK: wait until rxd_s==1, then → IDLE. This prevents restarting on a held-low line.
- Pulse widths: rx_valid and frame_err are each exactly 1 cycle and are never high together.
- Latency: rxd pin falling edge to rx_valid is 2+988 clocks (±1 for synchroniser phase).
- Reset mid-frame: returns to IDLE the next edge. The partial byte is discarded and no pulse is issued.
- No flow control: a new frame overwrites rx_byte. The consumer must capture it on rx_valid.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit (start, data, stop) is sampled at mid-1, mid and mid+1.
  - The 2-of-3 majority is the bit value.
  - Decision and shift occur at mid+1, so every sample time above shifts by +1 clock.
  - A 1-cycle glitch at mid cannot corrupt a bit.
- Undefined: a single sample at mid; no extra registers.

Decomposition:
- Shared package/header uart_pkg:
  - CLKS_PER_BIT default 104, shared with uart_tx.
  - State encodings IDLE=0, START=1, DATA=2, STOP=3, BREAK=4 (3-bit).
  - DATA_BITS=8.
- Sub-module sync_2ff: 1-bit, reset-to-1 two-flop synchroniser; reusable for other async inputs.

Test Plan:
- Loopback uart_tx→uart_rx, send 0x42 → exactly one rx_valid, rx_byte=0x42, frame_err=0, pulse ~990 clocks after tx start bit.
- Back-to-back 0xA5 then 0x5A with no idle gap → two rx_valid pulses 1040±2 clocks apart, bytes 0xA5 then 0x5A.
- rxd low for 20 clocks then high → no rx_valid/frame_err, rx_busy drops within 53 clocks of the edge, state IDLE.
- Frame 0x3C with stop bit driven low, preceded by a good 0x42:
  - frame_err pulses once, rx_byte stays 0x42.
  - With rxd held low a further 2000 clocks, no further pulses.
  - After rxd goes high, 0x55 is received correctly.
- Assert rst at bit 4 of 0xFF, release, then send 0x00 → no pulse for the aborted frame, then rx_valid with rx_byte=0x00.
- With UART_RX_MAJORITY_EN defined, inject a 1-clock inverted glitch at the mid-sample of bit 3 of 0x42 → rx_byte=0x42. Without the macro, the same stimulus yields 0x4A.
